// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, word/block types, key-schedule FSM states,
// the round-constant table and the RotWord helper.
package aes_pkg;

    localparam int unsigned NR        = 10;   // rounds for AES-128
    localparam int unsigned NK        = 4;    // 32-bit words per key
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned RK_ADDR_W = 4;    // addresses round keys 0..NR

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_t;

    // Round constant byte for round k (1..NR); zero outside that range.
    function automatic logic [7:0] rcon(input logic [RK_ADDR_W-1:0] k);
        logic [7:0] rc;
        case (k)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Left rotate by one byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
// Ports: data (byte in), subst (substituted byte out).
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    always_comb begin
        subst = 8'h00;
        case (data)
            8'h00: subst = 8'h63; 8'h01: subst = 8'h7c; 8'h02: subst = 8'h77; 8'h03: subst = 8'h7b;
            8'h04: subst = 8'hf2; 8'h05: subst = 8'h6b; 8'h06: subst = 8'h6f; 8'h07: subst = 8'hc5;
            8'h08: subst = 8'h30; 8'h09: subst = 8'h01; 8'h0a: subst = 8'h67; 8'h0b: subst = 8'h2b;
            8'h0c: subst = 8'hfe; 8'h0d: subst = 8'hd7; 8'h0e: subst = 8'hab; 8'h0f: subst = 8'h76;
            8'h10: subst = 8'hca; 8'h11: subst = 8'h82; 8'h12: subst = 8'hc9; 8'h13: subst = 8'h7d;
            8'h14: subst = 8'hfa; 8'h15: subst = 8'h59; 8'h16: subst = 8'h47; 8'h17: subst = 8'hf0;
            8'h18: subst = 8'had; 8'h19: subst = 8'hd4; 8'h1a: subst = 8'ha2; 8'h1b: subst = 8'haf;
            8'h1c: subst = 8'h9c; 8'h1d: subst = 8'ha4; 8'h1e: subst = 8'h72; 8'h1f: subst = 8'hc0;
            8'h20: subst = 8'hb7; 8'h21: subst = 8'hfd; 8'h22: subst = 8'h93; 8'h23: subst = 8'h26;
            8'h24: subst = 8'h36; 8'h25: subst = 8'h3f; 8'h26: subst = 8'hf7; 8'h27: subst = 8'hcc;
            8'h28: subst = 8'h34; 8'h29: subst = 8'ha5; 8'h2a: subst = 8'he5; 8'h2b: subst = 8'hf1;
            8'h2c: subst = 8'h71; 8'h2d: subst = 8'hd8; 8'h2e: subst = 8'h31; 8'h2f: subst = 8'h15;
            8'h30: subst = 8'h04; 8'h31: subst = 8'hc7; 8'h32: subst = 8'h23; 8'h33: subst = 8'hc3;
            8'h34: subst = 8'h18; 8'h35: subst = 8'h96; 8'h36: subst = 8'h05; 8'h37: subst = 8'h9a;
            8'h38: subst = 8'h07; 8'h39: subst = 8'h12; 8'h3a: subst = 8'h80; 8'h3b: subst = 8'he2;
            8'h3c: subst = 8'heb; 8'h3d: subst = 8'h27; 8'h3e: subst = 8'hb2; 8'h3f: subst = 8'h75;
            8'h40: subst = 8'h09; 8'h41: subst = 8'h83; 8'h42: subst = 8'h2c; 8'h43: subst = 8'h1a;
            8'h44: subst = 8'h1b; 8'h45: subst = 8'h6e; 8'h46: subst = 8'h5a; 8'h47: subst = 8'ha0;
            8'h48: subst = 8'h52; 8'h49: subst = 8'h3b; 8'h4a: subst = 8'hd6; 8'h4b: subst = 8'hb3;
            8'h4c: subst = 8'h29; 8'h4d: subst = 8'he3; 8'h4e: subst = 8'h2f; 8'h4f: subst = 8'h84;
            8'h50: subst = 8'h53; 8'h51: subst = 8'hd1; 8'h52: subst = 8'h00; 8'h53: subst = 8'hed;
            8'h54: subst = 8'h20; 8'h55: subst = 8'hfc; 8'h56: subst = 8'hb1; 8'h57: subst = 8'h5b;
            8'h58: subst = 8'h6a; 8'h59: subst = 8'hcb; 8'h5a: subst = 8'hbe; 8'h5b: subst = 8'h39;
            8'h5c: subst = 8'h4a; 8'h5d: subst = 8'h4c; 8'h5e: subst = 8'h58; 8'h5f: subst = 8'hcf;
            8'h60: subst = 8'hd0; 8'h61: subst = 8'hef; 8'h62: subst = 8'haa; 8'h63: subst = 8'hfb;
            8'h64: subst = 8'h43; 8'h65: subst = 8'h4d; 8'h66: subst = 8'h33; 8'h67: subst = 8'h85;
            8'h68: subst = 8'h45; 8'h69: subst = 8'hf9; 8'h6a: subst = 8'h02; 8'h6b: subst = 8'h7f;
            8'h6c: subst = 8'h50; 8'h6d: subst = 8'h3c; 8'h6e: subst = 8'h9f; 8'h6f: subst = 8'ha8;
            8'h70: subst = 8'h51; 8'h71: subst = 8'ha3; 8'h72: subst = 8'h40; 8'h73: subst = 8'h8f;
            8'h74: subst = 8'h92; 8'h75: subst = 8'h9d; 8'h76: subst = 8'h38; 8'h77: subst = 8'hf5;
            8'h78: subst = 8'hbc; 8'h79: subst = 8'hb6; 8'h7a: subst = 8'hda; 8'h7b: subst = 8'h21;
            8'h7c: subst = 8'h10; 8'h7d: subst = 8'hff; 8'h7e: subst = 8'hf3; 8'h7f: subst = 8'hd2;
            8'h80: subst = 8'hcd; 8'h81: subst = 8'h0c; 8'h82: subst = 8'h13; 8'h83: subst = 8'hec;
            8'h84: subst = 8'h5f; 8'h85: subst = 8'h97; 8'h86: subst = 8'h44; 8'h87: subst = 8'h17;
            8'h88: subst = 8'hc4; 8'h89: subst = 8'ha7; 8'h8a: subst = 8'h7e; 8'h8b: subst = 8'h3d;
            8'h8c: subst = 8'h64; 8'h8d: subst = 8'h5d; 8'h8e: subst = 8'h19; 8'h8f: subst = 8'h73;
            8'h90: subst = 8'h60; 8'h91: subst = 8'h81; 8'h92: subst = 8'h4f; 8'h93: subst = 8'hdc;
            8'h94: subst = 8'h22; 8'h95: subst = 8'h2a; 8'h96: subst = 8'h90; 8'h97: subst = 8'h88;
            8'h98: subst = 8'h46; 8'h99: subst = 8'hee; 8'h9a: subst = 8'hb8; 8'h9b: subst = 8'h14;
            8'h9c: subst = 8'hde; 8'h9d: subst = 8'h5e; 8'h9e: subst = 8'h0b; 8'h9f: subst = 8'hdb;
            8'ha0: subst = 8'he0; 8'ha1: subst = 8'h32; 8'ha2: subst = 8'h3a; 8'ha3: subst = 8'h0a;
            8'ha4: subst = 8'h49; 8'ha5: subst = 8'h06; 8'ha6: subst = 8'h24; 8'ha7: subst = 8'h5c;
            8'ha8: subst = 8'hc2; 8'ha9: subst = 8'hd3; 8'haa: subst = 8'hac; 8'hab: subst = 8'h62;
            8'hac: subst = 8'h91; 8'had: subst = 8'h95; 8'hae: subst = 8'he4; 8'haf: subst = 8'h79;
            8'hb0: subst = 8'he7; 8'hb1: subst = 8'hc8; 8'hb2: subst = 8'h37; 8'hb3: subst = 8'h6d;
            8'hb4: subst = 8'h8d; 8'hb5: subst = 8'hd5; 8'hb6: subst = 8'h4e; 8'hb7: subst = 8'ha9;
            8'hb8: subst = 8'h6c; 8'hb9: subst = 8'h56; 8'hba: subst = 8'hf4; 8'hbb: subst = 8'hea;
            8'hbc: subst = 8'h65; 8'hbd: subst = 8'h7a; 8'hbe: subst = 8'hae; 8'hbf: subst = 8'h08;
            8'hc0: subst = 8'hba; 8'hc1: subst = 8'h78; 8'hc2: subst = 8'h25; 8'hc3: subst = 8'h2e;
            8'hc4: subst = 8'h1c; 8'hc5: subst = 8'ha6; 8'hc6: subst = 8'hb4; 8'hc7: subst = 8'hc6;
            8'hc8: subst = 8'he8; 8'hc9: subst = 8'hdd; 8'hca: subst = 8'h74; 8'hcb: subst = 8'h1f;
            8'hcc: subst = 8'h4b; 8'hcd: subst = 8'hbd; 8'hce: subst = 8'h8b; 8'hcf: subst = 8'h8a;
            8'hd0: subst = 8'h70; 8'hd1: subst = 8'h3e; 8'hd2: subst = 8'hb5; 8'hd3: subst = 8'h66;
            8'hd4: subst = 8'h48; 8'hd5: subst = 8'h03; 8'hd6: subst = 8'hf6; 8'hd7: subst = 8'h0e;
            8'hd8: subst = 8'h61; 8'hd9: subst = 8'h35; 8'hda: subst = 8'h57; 8'hdb: subst = 8'hb9;
            8'hdc: subst = 8'h86; 8'hdd: subst = 8'hc1; 8'hde: subst = 8'h1d; 8'hdf: subst = 8'h9e;
            8'he0: subst = 8'he1; 8'he1: subst = 8'hf8; 8'he2: subst = 8'h98; 8'he3: subst = 8'h11;
            8'he4: subst = 8'h69; 8'he5: subst = 8'hd9; 8'he6: subst = 8'h8e; 8'he7: subst = 8'h94;
            8'he8: subst = 8'h9b; 8'he9: subst = 8'h1e; 8'hea: subst = 8'h87; 8'heb: subst = 8'he9;
            8'hec: subst = 8'hce; 8'hed: subst = 8'h55; 8'hee: subst = 8'h28; 8'hef: subst = 8'hdf;
            8'hf0: subst = 8'h8c; 8'hf1: subst = 8'ha1; 8'hf2: subst = 8'h89; 8'hf3: subst = 8'h0d;
            8'hf4: subst = 8'hbf; 8'hf5: subst = 8'he6; 8'hf6: subst = 8'h42; 8'hf7: subst = 8'h68;
            8'hf8: subst = 8'h41; 8'hf9: subst = 8'h99; 8'hfa: subst = 8'h2d; 8'hfb: subst = 8'h0f;
            8'hfc: subst = 8'hb0; 8'hfd: subst = 8'h54; 8'hfe: subst = 8'hbb; 8'hff: subst = 8'h16;
            default: subst = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// register file, read back through a registered random-access port.
// Ports:
//   clk, rest     - clock, async active-low reset
//   s, key_in     - start pulse and cipher key (byte 0 in [127:120])
//   busy, d       - expansion running / complete schedule held
//   rd_addr       - round-key index 0..10
//   rd_key        - round key for rd_addr sampled on the previous edge
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 s,
    input  logic [BLOCK_W-1:0]   key_in,
    output logic                 busy,
    output logic                 d,
    input  logic [RK_ADDR_W-1:0] rd_addr,
    output logic [BLOCK_W-1:0]   rd_key
);

    ks_state_t            state, state_nxt;
    logic [RK_ADDR_W-1:0] round, round_nxt;
    logic                 busy_nxt, d_nxt;
    logic                 load, step;

    block_t work;
    block_t store [NR+1];
    block_t next_key;
    block_t rd_mux;

    word_t  w   [NK];
    word_t  nw  [NK];
    word_t  rot, sub, temp;

    // SubWord(RotWord(w3)) via four byte S-boxes
    assign rot = rot_word(w[NK-1]);

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .data  (rot[8*i +: 8]),
            .subst (sub[8*i +: 8])
        );
    end

    // One key-expansion round from the working key
    always_comb begin
        for (int unsigned i = 0; i < NK; i++) begin
            w[i] = work[BLOCK_W-1-WORD_W*i -: WORD_W];
        end
        temp     = sub ^ {rcon(round), 24'h000000};
        nw[0]    = w[0] ^ temp;
        for (int unsigned i = 1; i < NK; i++) begin
            nw[i] = w[i] ^ nw[i-1];
        end
        next_key = {nw[0], nw[1], nw[2], nw[3]};
    end

    // Next-state and registered-output decode
    always_comb begin
        state_nxt = state;
        round_nxt = round;
        busy_nxt  = busy;
        d_nxt     = d;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (s) begin
                    state_nxt = ST_EXPAND;
                    round_nxt = 4'd1;
                    busy_nxt  = 1'b1;
                    d_nxt     = 1'b0;
                    load      = 1'b1;
                end
            end
            ST_EXPAND: begin
                // start requests are deliberately ignored here
                step      = 1'b1;
                round_nxt = round + 4'd1;
                if (round == 4'(NR)) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    d_nxt     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                d_nxt     = 1'b0;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state <= ST_IDLE;
            round <= '0;
            busy  <= 1'b0;
            d     <= 1'b0;
        end else begin
            state <= state_nxt;
            round <= round_nxt;
            busy  <= busy_nxt;
            d     <= d_nxt;
        end
    end

    // Working key and round-key storage; reset wipes every word
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            work <= '0;
            for (int unsigned i = 0; i <= NR; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (load) begin
                work     <= key_in;
                store[0] <= key_in;
            end else if (step) begin
                work <= next_key;
                for (int unsigned i = 1; i <= NR; i++) begin
                    if (round == 4'(i)) begin
                        store[i] <= next_key;
                    end
                end
            end
        end
    end

    // Read mux over the register file
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i <= NR; i++) begin
            if (rd_addr == 4'(i)) begin
                rd_mux = store[i];
            end
        end
    end

    // Registered read port, gated to zero unless a finished schedule is held
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rd_key <= '0;
        end else if (d && (rd_addr <= 4'(NR))) begin
            rd_key <= rd_mux;
        end else begin
            rd_key <= '0;
        end
    end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key-expansion stage that sits directly upstream of `inv_aes`. It expands one 128-bit cipher key into the 11 round keys, one round per clock, and stores them in an internal register file. The decrypt core reads the round keys in any order, including the reverse order that inverse rounds need, through a registered read port. A start/done handshake matches the one `inv_aes` uses.

## Interface
- `NR`, 10: number of rounds. Fixed for AES-128. Storage holds `NR+1` words.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rest`  in  1  asynchronous, active-low reset.
- `s`  in  1  start. Sampled on a rising edge. Launches an expansion of `key_in`.
- `key_in`  in  128  cipher key. Captured on the edge where `s` is accepted. Byte 0 is in bits [127:120].
- `busy`  out  1  high while the expansion is in progress.
- `d`  out  1  done/ready. High while a complete, valid schedule is held.
- `rd_addr`  in  4  round-key index, 0..10.
- `rd_key`  out  128  round key for the `rd_addr` sampled on the previous edge.

## Operation
- **Reset (`rest`=0):** `busy`=0, `d`=0, `rd_key`=0, round counter=0. All 11 storage words are cleared. State goes to IDLE.
- **FSM states:** IDLE, EXPAND, DONE.
- **IDLE / DONE, `s`=1 at an edge:**
  - Write `key_in` to word 0.
  - Load the working key register.
  - Set counter=1, `busy`=1, `d`=0, and enter EXPAND.
- **EXPAND, one round k = counter per edge:**
  - Compute the next key from the working key: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[k].
  - Then w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - Write the result to word k and to the working register. Increment the counter.
  - On the edge that writes k=10: `busy`=0, `d`=1, state becomes DONE.
- **`s` while in EXPAND:** ignored. The expansion in flight continues unchanged.
- **`s` in DONE:** a new expansion starts as in IDLE, and `d` falls on that same edge. A consumer must not use `rd_key` while `d`=0.
- **Read port:**
  - `rd_key` is registered: on each edge it takes the contents of word `rd_addr`.
  - It takes 0 instead when `d`=0 or `rd_addr`>10.
  - A read issued on the edge that sets `d` returns 0. Valid data starts with the first read after that edge.
- **Arithmetic:**
  - SubWord: the AES S-box applied bytewise.
  - RotWord: left byte rotate.
  - Rcon[k]: {rc_k, 24'h0}, where rc = 01,02,04,08,10,20,40,80,1b,36 for k=1..10.
- **Reset mid-expansion:** asynchronously aborts. All outputs return to reset values and storage is cleared. No partial schedule may survive the reset.

## Timing
- Latency: `s` accepted at edge N. Word k is written at edge N+k. `d`=1 from edge N+10.
- Total: 11 edges from `s` to a usable schedule.
- Read latency: 1 cycle from `rd_addr` to `rd_key`.
- Back-to-back reads at a different address every cycle are supported.
- `d` stays high indefinitely until the next accepted `s` or reset.

## Structure
- **Package `aes_pkg`:**
  - `NR`, `NK` constants.
  - `word_t` (32 b) and `block_t` (128 b) typedefs.
  - Rcon table.
  - State enum for the FSM.
  - Shared with `inv_aes` and `keygen`.
- **Sub-module `aes_sbox`:** combinational byte S-box, 256-entry case. Instantiated 4× for SubWord. The same block is reusable by the forward cipher.
- **Top:** FSM, counter, working register, 11×128 storage, read register.

## Test plan
- **FIPS-197 key:** `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `s` → `d` rises exactly 10 edges later. Reads must return:
  - rd 0 → 2b7e151628aed2a6abf7158809cf4f3c
  - rd 1 → a0fafe1788542cb123a339392a6c7605
  - rd 2 → f2c295f27a96b9435935807a7359f67f
  - rd 10 → d014f9a8c9ee2589e13f0cc8b6630ca6
- **All-zero key:**
  - rd 1 → 62636363626363636263636362636363
  - rd 10 → b4ef5bcb3e92e21123e951cf6f8f188e
- **Start while busy:** re-pulse `s` with the zero key at edge N+4 of a FIPS-197 run. The run must complete with the FIPS-197 values, and `d` must rise at N+10.
- **Restart from DONE:** after FIPS-197 completes, start with the zero key. `d` falls on the accepting edge, and rd 10 → b4ef…188e after the new `d`.
- **Reset mid-expansion:** assert `rest`=0 at N+5 → `busy`=`d`=`rd_key`=0 immediately. After release with no `s`, rd 0..10 all return 0.
- **Read boundaries:** with `d`=1, rd 11 and rd 15 → 0. Sweep rd 10 down to 0 on consecutive cycles → the stored values appear in order, one cycle late.
